// File: rtl/avg_pool_1d_pkg.sv
// avg_pool_1d_pkg: shared state encoding and geometry helpers for the 1-D pooling window generator
package avg_pool_1d_pkg;
  typedef enum logic [1:0] {ST_LEAD, ST_STREAM, ST_TAIL} state_t;
  function automatic int calc_plen(input int row_len, input int pad);
    return row_len + 2 * pad;
  endfunction
  function automatic int calc_n_out(input int row_len, input int pad, input int kernel, input int stride);
    return (calc_plen(row_len, pad) - kernel) / stride + 1;
  endfunction
endpackage

// File: rtl/avg_pool_1d_window_gen_shreg.sv
// pool_window_shreg: KERNEL-deep sample shift register; nxt is the contents after shifting din in
module pool_window_shreg #(
  parameter int DATA_W = 32,
  parameter int KERNEL = 4
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     en,
  input  logic [DATA_W-1:0]        din,
  output logic [KERNEL*DATA_W-1:0] nxt
);
  logic [KERNEL*DATA_W-1:0] q;
  logic [DATA_W-1:0] unused_oldest;
  assign unused_oldest = q[DATA_W-1:0];
  if (KERNEL == 1) begin : g_one
    assign nxt = din;
  end else begin : g_many
    assign nxt = {din, q[KERNEL*DATA_W-1:DATA_W]};
  end
  always_ff @(posedge clk) begin
    if (clr) q <= '0;
    else if (en) q <= nxt;
  end
endmodule

// File: rtl/avg_pool_1d_window_gen.sv
// avg_pool_1d_window_gen: turns a row of samples into zero-padded, strided KERNEL-wide windows
// with valid/ready on both sides; samples pass through bit-exact.
module avg_pool_1d_window_gen
  import avg_pool_1d_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int KERNEL  = 4,
  parameter int STRIDE  = 2,
  parameter int PAD     = 1,
  parameter int ROW_LEN = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_in,
  output logic                     ready_in,
  input  logic [DATA_W-1:0]        input_data,
  output logic                     valid_out,
  input  logic                     ready_out,
  output logic [KERNEL*DATA_W-1:0] window_data,
  output logic                     last_out
);
  localparam int PLEN  = calc_plen(ROW_LEN, PAD);
  localparam int N_OUT = calc_n_out(ROW_LEN, PAD, KERNEL, STRIDE);
  localparam int POS_W = PLEN > 1 ? $clog2(PLEN) : 1;
  localparam int PH_W  = STRIDE > 1 ? $clog2(STRIDE) : 1;
  localparam int IDX_W = $clog2(N_OUT + 1);
  localparam state_t ST_INIT = PAD > 0 ? ST_LEAD : ST_STREAM;
  logic [POS_W-1:0] pos;
  logic [PH_W-1:0] phase;
  logic [IDX_W-1:0] widx;
  state_t state, state_nxt;
  logic free, push, emit, row_end, in_win;
  logic [31:0] pos_nxt;
  logic [DATA_W-1:0] sample;
  logic [KERNEL*DATA_W-1:0] shifted;
  always_comb begin
    free      = !valid_out || ready_out;
    ready_in  = rst_n && state == ST_STREAM && free;
    push      = rst_n && free && (state != ST_STREAM || valid_in);
    sample    = state == ST_STREAM ? input_data : '0;
    row_end   = 32'(pos) == PLEN - 1;
    in_win    = 32'(pos) >= KERNEL - 1;
    emit      = push && in_win && phase == '0 && widx < IDX_W'(N_OUT);
    pos_nxt   = row_end ? 32'd0 : 32'(pos) + 32'd1;
    state_nxt = pos_nxt < PAD ? ST_LEAD : pos_nxt < PAD + ROW_LEN ? ST_STREAM : ST_TAIL;
  end
  pool_window_shreg #(.DATA_W(DATA_W), .KERNEL(KERNEL)) u_shreg (
    .clk (clk),
    .clr (!rst_n),
    .en  (push),
    .din (sample),
    .nxt (shifted)
  );
  // Window regs load the post-shift contents so the pushed sample is visible next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos         <= '0;
      phase       <= '0;
      widx        <= '0;
      state       <= ST_INIT;
      valid_out   <= 1'b0;
      last_out    <= 1'b0;
      window_data <= '0;
    end else begin
      if (push) begin
        pos   <= POS_W'(pos_nxt);
        state <= state_nxt;
        phase <= row_end || !in_win || phase == PH_W'(STRIDE - 1) ? '0 : phase + PH_W'(1);
        widx  <= row_end ? '0 : widx + IDX_W'(emit);
      end
      if (emit) begin
        valid_out   <= 1'b1;
        window_data <= shifted;
        last_out    <= widx == IDX_W'(N_OUT - 1);
      end else if (ready_out) begin
        valid_out <= 1'b0;
        last_out  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_avg_pool_1d_window_gen.sv
// tb_avg_pool_1d_window_gen: directed vector tables for three parameterisations of the window generator
module tb_avg_pool_1d_window_gen;
  typedef struct {
    logic [127:0] w;
    logic         l;
    int           cyc;
  } cap_t;
  typedef struct {
    int                  dut;
    int                  base;
    int                  n;
    int                  stall;
    int                  nexp;
    logic [7:0][127:0]   win;
    logic [7:0]          lst;
  } tcase_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vin[3], rin[3], vout[3], rout[3], lout[3];
  logic [31:0] din[3];
  logic [127:0] w0;
  logic [95:0] w1, w2;
  cap_t cap0[$], cap1[$], cap2[$];
  int acc[3];
  int cyc_n = 0;
  int vectors = 0;
  int errors = 0;
  tcase_t tc[5];
  always #5 clk = ~clk;
  avg_pool_1d_window_gen dut0 (
    .clk(clk), .rst_n(rst_n), .valid_in(vin[0]), .ready_in(rin[0]), .input_data(din[0]),
    .valid_out(vout[0]), .ready_out(rout[0]), .window_data(w0), .last_out(lout[0])
  );
  avg_pool_1d_window_gen #(.KERNEL(3), .STRIDE(1), .PAD(0), .ROW_LEN(5)) dut1 (
    .clk(clk), .rst_n(rst_n), .valid_in(vin[1]), .ready_in(rin[1]), .input_data(din[1]),
    .valid_out(vout[1]), .ready_out(rout[1]), .window_data(w1), .last_out(lout[1])
  );
  avg_pool_1d_window_gen #(.KERNEL(3), .STRIDE(2), .PAD(0), .ROW_LEN(6)) dut2 (
    .clk(clk), .rst_n(rst_n), .valid_in(vin[2]), .ready_in(rin[2]), .input_data(din[2]),
    .valid_out(vout[2]), .ready_out(rout[2]), .window_data(w2), .last_out(lout[2])
  );
  function automatic logic [127:0] w4(input int a, input int b, input int c, input int d);
    return {d[31:0], c[31:0], b[31:0], a[31:0]};
  endfunction
  function automatic logic [127:0] w3(input int a, input int b, input int c);
    return {32'd0, c[31:0], b[31:0], a[31:0]};
  endfunction
  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic tick();
    #1;
    if (vout[0] && rout[0]) cap0.push_back('{w0, lout[0], cyc_n});
    if (vout[1] && rout[1]) cap1.push_back('{{32'd0, w1}, lout[1], cyc_n});
    if (vout[2] && rout[2]) cap2.push_back('{{32'd0, w2}, lout[2], cyc_n});
    for (int d = 0; d < 3; d++) if (vin[d] && rin[d]) acc[d]++;
    cyc_n++;
    @(negedge clk);
  endtask
  task automatic clear_caps();
    cap0.delete();
    cap1.delete();
    cap2.delete();
    for (int d = 0; d < 3; d++) acc[d] = 0;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      vin[d] = 1'b0;
      rout[d] = 1'b1;
      din[d] = '0;
    end
    tick();
    tick();
    check("rst ready_in", 128'(rin[1]), 128'd0);
    rst_n = 1'b1;
    #1;
    check("rst valid_out", 128'(vout[0]), 128'd0);
    check("rst last_out", 128'(lout[0]), 128'd0);
    check("rst window_data", w0, 128'd0);
    clear_caps();
  endtask
  task automatic run(input int d, input int base, input int n, input int stall, input logic [127:0] first);
    int sc = 0;
    int drain = 0;
    int guard = 0;
    while ((acc[d] < n || drain < 12) && guard < 400) begin
      vin[d] = acc[d] < n;
      din[d] = base + acc[d];
      rout[d] = !(vout[d] && sc < stall);
      if (!rout[d]) begin
        sc++;
        #1;
        check("stall window held", w0, first);
        check("stall ready_in", 128'(rin[0]), 128'd0);
      end
      tick();
      guard++;
      if (acc[d] >= n) drain++;
    end
    vin[d] = 1'b0;
    rout[d] = 1'b1;
    check("samples accepted", 128'(acc[d]), 128'(n));
  endtask
  task automatic compare(input int t);
    cap_t q[$];
    if (tc[t].dut == 0) q = cap0;
    else if (tc[t].dut == 1) q = cap1;
    else q = cap2;
    check($sformatf("t%0d window count", t), 128'(q.size()), 128'(tc[t].nexp));
    for (int i = 0; i < tc[t].nexp; i++) begin
      if (i < q.size()) begin
        check($sformatf("t%0d win%0d", t, i), q[i].w, tc[t].win[i]);
        check($sformatf("t%0d last%0d", t, i), 128'(q[i].l), 128'(tc[t].lst[i]));
      end
    end
    if (t == 3 && q.size() >= 3)
      for (int i = 1; i < 3; i++)
        check($sformatf("t3 consecutive%0d", i), 128'(q[i].cyc - q[i-1].cyc), 128'd1);
  endtask
  initial begin
    tc[0].dut = 0; tc[0].base = 1; tc[0].n = 8; tc[0].stall = 0; tc[0].nexp = 4;
    tc[0].win = '0; tc[0].lst = 8'b0000_1000;
    tc[0].win[0] = w4(0, 1, 2, 3);
    tc[0].win[1] = w4(2, 3, 4, 5);
    tc[0].win[2] = w4(4, 5, 6, 7);
    tc[0].win[3] = w4(6, 7, 8, 0);
    tc[1] = tc[0];
    tc[1].stall = 5;
    tc[2] = tc[0];
    tc[2].n = 16; tc[2].nexp = 8; tc[2].lst = 8'b1000_1000;
    tc[2].win[4] = w4(0, 9, 10, 11);
    tc[2].win[5] = w4(10, 11, 12, 13);
    tc[2].win[6] = w4(12, 13, 14, 15);
    tc[2].win[7] = w4(14, 15, 16, 0);
    tc[3].dut = 1; tc[3].base = 1; tc[3].n = 5; tc[3].stall = 0; tc[3].nexp = 3;
    tc[3].win = '0; tc[3].lst = 8'b0000_0100;
    tc[3].win[0] = w3(1, 2, 3);
    tc[3].win[1] = w3(2, 3, 4);
    tc[3].win[2] = w3(3, 4, 5);
    tc[4].dut = 2; tc[4].base = 1; tc[4].n = 6; tc[4].stall = 0; tc[4].nexp = 2;
    tc[4].win = '0; tc[4].lst = 8'b0000_0010;
    tc[4].win[0] = w3(1, 2, 3);
    tc[4].win[1] = w3(3, 4, 5);
    for (int d = 0; d < 3; d++) begin
      vin[d] = 1'b0;
      rout[d] = 1'b1;
      din[d] = '0;
      acc[d] = 0;
    end
    @(negedge clk);
    for (int t = 0; t < 5; t++) begin
      do_reset();
      run(tc[t].dut, tc[t].base, tc[t].n, tc[t].stall, tc[t].win[0]);
      compare(t);
    end
    do_reset();
    for (int g = 0; g < 50 && acc[0] < 4; g++) begin
      vin[0] = 1'b1;
      din[0] = 1 + acc[0];
      tick();
    end
    vin[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid-row reset ready_in", 128'(rin[0]), 128'd0);
    tick();
    check("mid-row reset valid_out", 128'(vout[0]), 128'd0);
    rst_n = 1'b1;
    clear_caps();
    run(0, 1, 8, 0, tc[0].win[0]);
    compare(0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
